// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - request ports and register file write bus of the writeback arbiter
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              stall;
  logic              a_valid;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_rd;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              wr_enable;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic              b_starved;

  modport master (
    output stall, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  a_ready, b_ready, wr_enable, wr_rd, wr_data, b_starved
  );

  modport slave (
    input  stall, a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output a_ready, b_ready, wr_enable, wr_rd, wr_data, b_starved
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-source register file write port arbiter with starvation guard
// Optional grant statistics enabled by WB_ARB_STATS_EN.
module wb_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic        clock,
  input  logic        reset_n,
`ifdef WB_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] a_grant_cnt,
  output logic [15:0] b_grant_cnt,
`endif
  wb_port_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt;
  logic              starved;
  logic              run;
  logic              grant_a;
  logic              grant_b;
  logic              wr_enable_q;
  logic [ADDR_W-1:0] wr_rd_q;
  logic [DATA_W-1:0] wr_data_q;

  assign starved = (starve_cnt == STARVE_LIM);

  // Readies are gated by reset so nothing is accepted while the block is held in reset.
  always_comb begin
    run     = reset_n && !bus.stall;
    grant_b = run && bus.b_valid && (starved || !bus.a_valid);
    grant_a = run && bus.a_valid && !grant_b;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (grant_b) begin
      starve_cnt <= '0;
    end else if (grant_a && bus.b_valid && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Register x0 is hardwired zero, so its slot is consumed without a write strobe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_enable_q <= 1'b0;
      wr_rd_q     <= '0;
      wr_data_q   <= '0;
    end else begin
      wr_enable_q <= (grant_a && (bus.a_rd != '0)) || (grant_b && (bus.b_rd != '0));
      if (grant_a) begin
        wr_rd_q   <= bus.a_rd;
        wr_data_q <= bus.a_data;
      end else if (grant_b) begin
        wr_rd_q   <= bus.b_rd;
        wr_data_q <= bus.b_data;
      end
    end
  end

  assign bus.a_ready   = grant_a;
  assign bus.b_ready   = grant_b;
  assign bus.wr_enable = wr_enable_q;
  assign bus.wr_rd     = wr_rd_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.b_starved = starved;

`ifdef WB_ARB_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else if (stats_clr) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else begin
      if (grant_a && (a_grant_cnt != 16'hFFFF)) a_grant_cnt <= a_grant_cnt + 16'd1;
      if (grant_b && (b_grant_cnt != 16'hFFFF)) b_grant_cnt <= b_grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized self-checking bench for wb_port_arbiter against a behavioural model
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SMAX = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

`ifdef WB_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] a_grant_cnt;
  logic [15:0] b_grant_cnt;
  int          m_acnt = 0;
  int          m_bcnt = 0;
`endif

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .clock(clock),
    .reset_n(reset_n),
`ifdef WB_ARB_STATS_EN
    .stats_clr(stats_clr),
    .a_grant_cnt(a_grant_cnt),
    .b_grant_cnt(b_grant_cnt),
`endif
    .bus(bus)
  );

  always #5 clock = ~clock;

  // Behavioural model: blocked-count of B, plus the write slot it expects next cycle.
  int          m_cnt = 0;
  bit          m_wr_en = 0;
  logic [AW-1:0] m_wr_rd = '0;
  logic [DW-1:0] m_wr_data = '0;

  function automatic void model_grant(output bit ga, output bit gb);
    ga = 0;
    gb = 0;
    if (reset_n && !bus.stall) begin
      if (m_cnt >= SMAX && bus.b_valid) gb = 1;
      else if (bus.a_valid) ga = 1;
      else if (bus.b_valid) gb = 1;
    end
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_wr_en = 0; m_wr_rd = '0; m_wr_data = '0;
`ifdef WB_ARB_STATS_EN
    m_acnt = 0; m_bcnt = 0;
`endif
  endtask

  task automatic tick(output bit ga, output bit gb);
    model_grant(ga, gb);
    @(posedge clock);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_wr_en = (ga && bus.a_rd != 0) || (gb && bus.b_rd != 0);
      if (ga) begin m_wr_rd = bus.a_rd; m_wr_data = bus.a_data; end
      else if (gb) begin m_wr_rd = bus.b_rd; m_wr_data = bus.b_data; end
      if (gb) m_cnt = 0;
      else if (ga && bus.b_valid) m_cnt = (m_cnt + 1 > SMAX) ? SMAX : m_cnt + 1;
`ifdef WB_ARB_STATS_EN
      if (stats_clr) begin m_acnt = 0; m_bcnt = 0; end
      else begin
        if (ga && m_acnt < 16'hFFFF) m_acnt++;
        if (gb && m_bcnt < 16'hFFFF) m_bcnt++;
      end
`endif
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.a_valid = 0; bus.a_rd = '0; bus.a_data = '0;
    bus.b_valid = 0; bus.b_rd = '0; bus.b_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bit ga, gb;
    idle_inputs();
    bus.a_valid = 1; bus.b_valid = 1;
    #1;
    checks++; if (bus.a_ready !== 0 || bus.b_ready !== 0) begin errors++;
      $display("FAIL reset_ready: a=%b b=%b expected 0 0", bus.a_ready, bus.b_ready); end
    checks++; if (bus.wr_enable !== 0 || bus.wr_rd !== 0 || bus.wr_data !== 0 || bus.b_starved !== 0) begin errors++;
      $display("FAIL reset_outputs: en=%b rd=%0d data=%h starved=%b expected zeros",
               bus.wr_enable, bus.wr_rd, bus.wr_data, bus.b_starved); end
    do_reset();
    bus.a_valid = 1; bus.a_rd = 5; bus.a_data = 32'hDEADBEEF;
    #1;
    checks++; if (bus.a_ready !== 1) begin errors++;
      $display("FAIL midreset_accept: a_ready=%b expected 1", bus.a_ready); end
    tick(ga, gb);
    checks++; if (bus.wr_enable !== 1) begin errors++;
      $display("FAIL midreset_pending: wr_enable=%b expected 1", bus.wr_enable); end
    bus.a_valid = 0;
    #2 reset_n = 0;
    #1;
    checks++; if (bus.wr_enable !== 0) begin errors++;
      $display("FAIL midreset_async_drop: wr_enable=%b expected 0", bus.wr_enable); end
    model_reset();
    @(negedge clock);
    reset_n = 1;
    tick(ga, gb);
    checks++; if (bus.wr_enable !== 0 || bus.wr_rd !== 0 || bus.wr_data !== 0 || bus.b_starved !== 0) begin errors++;
      $display("FAIL midreset_after: en=%b rd=%0d data=%h starved=%b expected zeros",
               bus.wr_enable, bus.wr_rd, bus.wr_data, bus.b_starved); end
  endtask

  task automatic test_single_a();
    bit ga, gb;
    do_reset();
    bus.a_valid = 1; bus.a_rd = 7; bus.a_data = 32'h12345678;
    #1;
    checks++; if (bus.a_ready !== 1 || bus.b_ready !== 0) begin errors++;
      $display("FAIL single_a_ready: a=%b b=%b expected 1 0", bus.a_ready, bus.b_ready); end
    tick(ga, gb);
    bus.a_valid = 0;
    #1;
    checks++; if (bus.wr_enable !== 1 || bus.wr_rd !== 7 || bus.wr_data !== 32'h12345678) begin errors++;
      $display("FAIL single_a_write: en=%b rd=%0d data=%h expected 1 7 12345678",
               bus.wr_enable, bus.wr_rd, bus.wr_data); end
    tick(ga, gb);
    checks++; if (bus.wr_enable !== 0 || bus.wr_data !== 32'h12345678) begin errors++;
      $display("FAIL single_a_oneshot: en=%b data=%h expected 0 12345678 (held)", bus.wr_enable, bus.wr_data); end
  endtask

  task automatic test_x0();
    bit ga, gb;
    do_reset();
    bus.b_valid = 1; bus.b_rd = 0; bus.b_data = 32'hFFFFFFFF;
    #1;
    checks++; if (bus.b_ready !== 1 || bus.a_ready !== 0) begin errors++;
      $display("FAIL x0_ready: b=%b a=%b expected 1 0", bus.b_ready, bus.a_ready); end
    tick(ga, gb);
    bus.b_valid = 0;
    #1;
    checks++; if (bus.wr_enable !== 0) begin errors++;
      $display("FAIL x0_suppress: wr_enable=%b expected 0", bus.wr_enable); end
  endtask

  task automatic test_starvation();
    bit ga, gb;
    bit exp_a[5] = '{1, 1, 1, 0, 1};
    bit exp_s[5] = '{0, 0, 0, 1, 0};
    do_reset();
    bus.a_valid = 1; bus.a_rd = 1; bus.b_valid = 1; bus.b_rd = 2;
    for (int i = 0; i < 5; i++) begin
      bus.a_data = 32'hA000 + i; bus.b_data = 32'hB000 + i;
      #1;
      checks++; if (bus.a_ready !== exp_a[i] || bus.b_ready !== !exp_a[i] || bus.b_starved !== exp_s[i]) begin
        errors++;
        $display("FAIL starve_cycle%0d: a=%b b=%b starved=%b expected %b %b %b",
                 i + 1, bus.a_ready, bus.b_ready, bus.b_starved, exp_a[i], !exp_a[i], exp_s[i]); end
      tick(ga, gb);
    end
  endtask

  task automatic test_stall();
    bit ga, gb;
    do_reset();
    bus.a_valid = 1; bus.a_rd = 3; bus.a_data = 32'hA1;
    bus.b_valid = 1; bus.b_rd = 4; bus.b_data = 32'hB1;
    tick(ga, gb);
    bus.a_data = 32'hA2;
    bus.stall = 1;
    #1;
    checks++; if (bus.wr_enable !== 1 || bus.wr_data !== 32'hA1) begin errors++;
      $display("FAIL stall_inflight: en=%b data=%h expected 1 a1", bus.wr_enable, bus.wr_data); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.a_ready !== 0 || bus.b_ready !== 0 || bus.b_starved !== 0) begin errors++;
        $display("FAIL stall_block%0d: a=%b b=%b starved=%b expected 0 0 0",
                 i, bus.a_ready, bus.b_ready, bus.b_starved); end
      tick(ga, gb);
    end
    bus.stall = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.a_ready !== (i < 2) || bus.b_ready !== (i == 2)) begin errors++;
        $display("FAIL stall_resume%0d: a=%b b=%b expected %b %b",
                 i, bus.a_ready, bus.b_ready, (i < 2), (i == 2)); end
      tick(ga, gb);
    end
    idle_inputs();
  endtask

  task automatic test_same_rd();
    bit ga, gb;
    do_reset();
`ifdef WB_ARB_STATS_EN
    stats_clr = 1; tick(ga, gb); stats_clr = 0;
`endif
    bus.a_valid = 1; bus.a_rd = 9; bus.a_data = 1;
    bus.b_valid = 1; bus.b_rd = 9; bus.b_data = 2;
    tick(ga, gb);
    bus.a_valid = 0;
    #1;
    checks++; if (bus.wr_enable !== 1 || bus.wr_rd !== 9 || bus.wr_data !== 1) begin errors++;
      $display("FAIL same_rd_first: en=%b rd=%0d data=%0d expected 1 9 1", bus.wr_enable, bus.wr_rd, bus.wr_data); end
    tick(ga, gb);
    bus.b_valid = 0;
    #1;
    checks++; if (bus.wr_enable !== 1 || bus.wr_rd !== 9 || bus.wr_data !== 2) begin errors++;
      $display("FAIL same_rd_second: en=%b rd=%0d data=%0d expected 1 9 2", bus.wr_enable, bus.wr_rd, bus.wr_data); end
`ifdef WB_ARB_STATS_EN
    checks++; if (a_grant_cnt !== 16'd1 || b_grant_cnt !== 16'd1) begin errors++;
      $display("FAIL same_rd_stats: a=%0d b=%0d expected 1 1", a_grant_cnt, b_grant_cnt); end
`endif
  endtask

  task automatic test_random();
    bit ga, gb;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!bus.a_valid && $urandom_range(0, 2) != 0) begin
        bus.a_valid = 1;
        bus.a_rd = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
        bus.a_data = $urandom;
      end
      if (!bus.b_valid && $urandom_range(0, 2) != 0) begin
        bus.b_valid = 1;
        bus.b_rd = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
        bus.b_data = $urandom;
      end
      bus.stall = ($urandom_range(0, 4) == 0);
`ifdef WB_ARB_STATS_EN
      stats_clr = ($urandom_range(0, 40) == 0);
`endif
      #1;
      model_grant(ga, gb);
      checks++; if (bus.a_ready !== ga || bus.b_ready !== gb) begin errors++;
        $display("FAIL rand_grant@%0d: a=%b b=%b expected %b %b", cyc, bus.a_ready, bus.b_ready, ga, gb); end
      checks++; if (bus.b_starved !== (m_cnt == SMAX)) begin errors++;
        $display("FAIL rand_starved@%0d: %b expected %b", cyc, bus.b_starved, (m_cnt == SMAX)); end
      checks++; if (bus.wr_enable !== m_wr_en ||
                    (m_wr_en && (bus.wr_rd !== m_wr_rd || bus.wr_data !== m_wr_data))) begin errors++;
        $display("FAIL rand_write@%0d: en=%b rd=%0d data=%h expected %b %0d %h",
                 cyc, bus.wr_enable, bus.wr_rd, bus.wr_data, m_wr_en, m_wr_rd, m_wr_data); end
`ifdef WB_ARB_STATS_EN
      checks++; if (a_grant_cnt !== 16'(m_acnt) || b_grant_cnt !== 16'(m_bcnt)) begin errors++;
        $display("FAIL rand_stats@%0d: a=%0d b=%0d expected %0d %0d", cyc, a_grant_cnt, b_grant_cnt, m_acnt, m_bcnt); end
`endif
      tick(ga, gb);
      if (ga) bus.a_valid = 0;
      if (gb) bus.b_valid = 0;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_x0();
    test_starvation();
    test_stall();
    test_same_rd();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the register file's single write port between two writeback sources: port A, the in-order ALU pipeline result, and port B, the multi-cycle load/multiply unit. Each source uses a valid/ready handshake. One accepted request per cycle is registered and driven onto the register file write interface (enable, rd, data). A starvation counter guarantees forward progress for port B.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, width of destination register index
STARVE_MAX, 3, consecutive cycles port B may be blocked by A before B is forced priority (legal range 1..15)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  pipeline hold; no grants while high
a_valid  in  1  port A request valid
a_rd  in  ADDR_W  port A destination register
a_data  in  DATA_W  port A write data
a_ready  out  1  port A request accepted this cycle
b_valid  in  1  port B request valid
b_rd  in  ADDR_W  port B destination register
b_data  in  DATA_W  port B write data
b_ready  out  1  port B request accepted this cycle
wr_enable  out  1  register file write enable
wr_rd  out  ADDR_W  register file write address
wr_data  out  DATA_W  register file write data
b_starved  out  1  high while port B has forced priority

Behaviour:
- Reset (async assert, sync-safe deassert by clock): wr_enable=0, wr_rd=0, wr_data=0, starvation counter=0, b_starved=0. a_ready and b_ready are combinational and are 0 during reset.
- Handshake: a transfer occurs on a rising edge where valid&&ready. A requester holds valid, rd and data stable until accepted. The ready outputs depend combinationally on valid, stall and arbitration state, never on the requester's data.
- Grant logic (combinational):
  - stall=1: a_ready=b_ready=0.
  - Otherwise, if b_starved=1 and b_valid=1: grant B.
  - Otherwise A has fixed priority: a_valid grants A, else b_valid grants B.
  - a_ready and b_ready are never both 1.
- Starvation counter:
  - Increments each non-stalled cycle in which b_valid=1 and A is granted.
  - Clears on any B grant.
  - Holds during stall.
  - Holds when b_valid=0.
  - b_starved = (counter == STARVE_MAX).
  - Counter saturates at STARVE_MAX.
- Output stage: one-cycle latency. A request accepted at edge N drives wr_enable=1, wr_rd and wr_data for exactly the cycle after edge N. With no grant, wr_enable=0 and wr_rd/wr_data hold their last values.
- x0 protection: a request with rd==0 is accepted normally (ready asserted), but wr_enable stays 0 for that slot.
- Same rd on A and B in one cycle: only the granted one is written. The other waits and is written in a later cycle, so write order equals grant order.
- stall asserted while a write is in the output stage: that write still completes. stall blocks only new grants.
- reset_n asserted mid-operation: the pending output write is discarded immediately (wr_enable drops asynchronously) and the counter is cleared. Requesters must re-present their requests after reset.

Optional Feature:
Macro WB_ARB_STATS_EN. When defined, the block adds two outputs, a_grant_cnt and b_grant_cnt, each 16 bits.
- Each counts accepted transfers on its port, including rd==0 transfers.
- Each saturates at 16'hFFFF.
- Both reset to 0.
- Both clear synchronously when the added input stats_clr is 1; clear wins over a simultaneous increment.
When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset mid-write: accept A (rd=5, data=0xDEADBEEF), assert reset_n=0 before the next edge -> wr_enable falls immediately, no write of r5; after release all outputs are 0.
2. Single A: a_valid=1, rd=7, data=0x12345678, idle B -> a_ready=1 at edge N; at N+1 wr_enable=1, wr_rd=7, wr_data=0x12345678 for one cycle only.
3. x0 write: b_valid=1, rd=0, data=0xFFFFFFFF -> b_ready=1, wr_enable stays 0 in the following cycle.
4. Starvation: A and B valid continuously, STARVE_MAX=3 -> A granted 3 cycles, b_starved=1 in cycle 4, B granted in cycle 4, counter returns to 0, A granted in cycle 5.
5. Stall: both valid with stall=1 for 4 cycles -> a_ready=b_ready=0, counter unchanged, an in-flight write still appears. After release, A is granted first.
6. Same rd: A rd=9 data=1 and B rd=9 data=2 in the same cycle -> r9 written with 1, then 2 the next cycle (with stats enabled: a_grant_cnt=1, b_grant_cnt=1).
